output_result_buffer: RTL and testbench
=======================================

OUTPUT_RESULT_BUFFER -- requirements
Module: output_result_buffer

Interface
REQ-001 Parameter ADC_BITS, default 4: width of each ADC result.
REQ-002 Parameter DEPTH, default 16: result FIFO entries; must be a power of 2.
REQ-003 Parameter CONV_CYCLES, default 4: cycles CLK_EN_ADCx is held high per conversion; range 1..15.
REQ-004 Parameter DATA_W, default 32: width of the readout word.
REQ-005 Port clk, in, 1: single clock; all state updates on its rising edge.
REQ-006 Port rst, in, 1: reset, asynchronous and active-low.
REQ-007 Port cap_start, in, 1: one-cycle pulse from the instruction decoder that launches a capture.
REQ-008 Port cap_mode, in, 1: capture type; 0 = READ via CSA, 1 = MAC via ADC.
REQ-009 Port cap_sel, in, 1: sense path; 0 = MUX1 path, 1 = MUX2 path.
REQ-010 Port cap_count, in, 5: number of MAC samples, 0..16.
REQ-011 Port csa_out1 and csa_out2, in, 1 each: sense-amp outputs for path 1 and path 2.
REQ-012 Port adc_out1 and adc_out2, in, ADC_BITS each: ADC outputs for path 1 and path 2.
REQ-013 Port CLK_EN_ADC1 and CLK_EN_ADC2, out, 1 each: ADC conversion enables.
REQ-014 Port busy, out, 1: high whenever the FSM is not in IDLE.
REQ-015 Port wishbone_rd_en_output_buffer, in, 1: bus pop request.
REQ-016 Port wishbone_databus_out, out, DATA_W: FIFO head word, registered.
REQ-017 Port wishbone_empty_output_buffer and wishbone_full_output_buffer, out, 1 each: FIFO status flags.
REQ-018 Port overflow, out, 1: sticky flag for a dropped push.
REQ-019 Port clear_overflow, in, 1: synchronous clear of overflow.

Function
REQ-020 FSM states: IDLE, SETTLE, CONVERT, SAMPLE.
REQ-021 IDLE transitions on cap_start:
  - cap_mode=0 -> SETTLE.
  - cap_mode=1 with cap_count>0 -> CONVERT.
  - cap_mode=1 with cap_count=0 -> stays IDLE; no push.
  - cap_mode, cap_sel and cap_count are latched on the start cycle.
REQ-022 SETTLE lasts 1 cycle -> SAMPLE; the selected csa_outX is sampled at the end of SETTLE.
REQ-023 CONVERT:
  - CLK_EN_ADC1 (cap_sel=0) or CLK_EN_ADC2 (cap_sel=1) is high for exactly CONV_CYCLES cycles, then -> SAMPLE.
  - The other enable stays 0.
  - The selected adc_outX is captured on the last CONVERT cycle.
REQ-024 SAMPLE:
  - Pushes one word, increments the sample index and decrements remaining.
  - -> CONVERT if MAC and remaining>0, else -> IDLE.
  - One SAMPLE cycle separates consecutive conversions, during which both enables are 0.
REQ-025 Word format:
  - [31] = mode.
  - [30] = sel.
  - [29:24] = sample index, starting at 0.
  - [15:0] = data, zero-extended.
  - Other bits are 0.
REQ-026 cap_start while busy is ignored and has no side effect.
REQ-027 FIFO pop:
  - wishbone_rd_en_output_buffer when not empty loads the head into wishbone_databus_out on the next edge.
  - A pop when empty is ignored and the output holds.
REQ-028 FIFO push when full is dropped and sets overflow; a simultaneous pop and push when full both succeed.
REQ-029 Pointers wrap modulo DEPTH; full = count==DEPTH and empty = count==0, both registered flags.
REQ-030 overflow clears only on clear_overflow or reset; if set and clear occur in the same cycle, set wins.
REQ-031 Total MAC latency from cap_start to the last push = cap_count*(CONV_CYCLES+1) cycles; READ latency = 2 cycles.

Reset
REQ-032 Asserting rst asynchronously returns the block to its reset state, including mid-capture:
  - FSM = IDLE; FIFO pointers and count = 0.
  - wishbone_databus_out = 0, empty = 1, full = 0, overflow = 0.
  - CLK_EN_ADC1/2 = 0, busy = 0.
REQ-033 No push or pop occurs on the first edge after rst deasserts unless requested on that edge.

Configuration
REQ-034 Macro RESULT_ACCUM_EN, when defined:
  - A MAC capture sums all samples into an (ADC_BITS+4)-bit accumulator.
  - It pushes a single word at the final SAMPLE, with index = cap_count-1 and data = sum.
  - READ is unchanged.
REQ-035 Without RESULT_ACCUM_EN, each MAC sample is pushed individually; no accumulator logic exists.

Verification
REQ-036 Test: READ of path 1.
  - Stimulus: cap_mode=0, cap_sel=0, csa_out1=1.
  - Response: one word 0x0000_0001 after 2 cycles; busy high for 2 cycles; CLK_EN_ADCx stay 0.
REQ-037 Test: MAC on path 2.
  - Stimulus: cap_mode=1, cap_sel=1, cap_count=3, adc_out2 = 5, 9, 15 per conversion.
  - Response: CLK_EN_ADC2 is high in three 4-cycle pulses.
  - Without the macro, words 0xC000_0005, 0xC100_0009, 0xC200_000F.
  - With RESULT_ACCUM_EN, a single word 0xC200_001D.
REQ-038 Test: FIFO full.
  - Stimulus: 17 READ captures with no pops.
  - Response: full=1 after the 16th; the 17th is dropped and overflow=1; clear_overflow returns it to 0.
REQ-039 Test: reset mid-capture.
  - Stimulus: rst low in the 2nd CONVERT cycle.
  - Response: CLK_EN_ADCx=0 immediately, empty=1, and the next cap_start behaves normally.
REQ-040 Test: start while busy and count 0.
  - Stimulus: cap_start during CONVERT, then a later cap_start with cap_count=0.
  - Response: neither produces a push or a state change.

Source files
------------

// File: rtl/output_result_buffer.sv
// output_result_buffer
//   Capture sequencer for CSA (READ) and ADC (MAC) results, feeding a result
//   FIFO that is drained over the wishbone readout port.
//   Optional build macro: RESULT_ACCUM_EN. When defined, a MAC capture sums
//   its samples and pushes one word. Otherwise each sample is pushed.
//   Readout word: [31] mode, [30] sel, [29:24] sample index, [15:0] data.
module output_result_buffer #(
  parameter int ADC_BITS    = 4,
  parameter int DEPTH       = 16,
  parameter int CONV_CYCLES = 4,
  parameter int DATA_W      = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cap_start,
  input  logic                cap_mode,
  input  logic                cap_sel,
  input  logic [4:0]          cap_count,
  input  logic                csa_out1,
  input  logic                csa_out2,
  input  logic [ADC_BITS-1:0] adc_out1,
  input  logic [ADC_BITS-1:0] adc_out2,
  output logic                CLK_EN_ADC1,
  output logic                CLK_EN_ADC2,
  output logic                busy,
  input  logic                wishbone_rd_en_output_buffer,
  output logic [DATA_W-1:0]   wishbone_databus_out,
  output logic                wishbone_empty_output_buffer,
  output logic                wishbone_full_output_buffer,
  output logic                overflow,
  input  logic                clear_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0]  CONV_LAST = 4'(CONV_CYCLES - 1);
  localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, SETTLE, CONVERT, SAMPLE} state_t;

  state_t          state, state_nxt;
  logic            mode_q, sel_q;
  logic [4:0]      remain_q;
  logic [5:0]      idx_q;
  logic [3:0]      cnt_q;
  logic [15:0]     data_q;
  logic            conv_last;
  logic            push;
  logic [ADC_BITS-1:0] adc_sel;
  logic [DATA_W-1:0]   push_word;

`ifdef RESULT_ACCUM_EN
  localparam int ACC_W = ADC_BITS + 4;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_nxt;
`endif

  // FIFO state
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count_q, count_nxt;
  logic              pop_ok, push_ok, ovf_set;

  assign adc_sel   = sel_q ? adc_out2 : adc_out1;
  assign conv_last = (cnt_q == CONV_LAST);
  assign push_word = DATA_W'({mode_q, sel_q, idx_q, 8'b0, data_q});

`ifdef RESULT_ACCUM_EN
  assign acc_nxt = acc_q + ACC_W'(adc_sel);
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // FSM next state, enables and push strobe
  always_comb begin
    state_nxt   = state;
    CLK_EN_ADC1 = 1'b0;
    CLK_EN_ADC2 = 1'b0;
    busy        = (state != IDLE);
    push        = 1'b0;
    case (state)
      IDLE: begin
        if (cap_start) begin
          if (!cap_mode)              state_nxt = SETTLE;
          else if (cap_count != 5'd0) state_nxt = CONVERT;
        end
      end
      SETTLE: state_nxt = SAMPLE;
      CONVERT: begin
        CLK_EN_ADC1 = !sel_q;
        CLK_EN_ADC2 = sel_q;
        if (conv_last) state_nxt = SAMPLE;
      end
      SAMPLE: begin
`ifdef RESULT_ACCUM_EN
        // Accumulating MAC only emits the running sum on its final sample
        push = !mode_q || (remain_q == 5'd1);
`else
        push = 1'b1;
`endif
        if (mode_q && remain_q > 5'd1) state_nxt = CONVERT;
        else                           state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture context, conversion counter and sampled data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q   <= 1'b0;
      sel_q    <= 1'b0;
      remain_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
`ifdef RESULT_ACCUM_EN
      acc_q    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cap_start) begin
            mode_q   <= cap_mode;
            sel_q    <= cap_sel;
            remain_q <= cap_count;
            idx_q    <= '0;
            cnt_q    <= '0;
`ifdef RESULT_ACCUM_EN
            acc_q    <= '0;
`endif
          end
        end
        SETTLE: data_q <= {15'b0, (sel_q ? csa_out2 : csa_out1)};
        CONVERT: begin
          cnt_q <= conv_last ? 4'd0 : cnt_q + 4'd1;
          if (conv_last) begin
`ifdef RESULT_ACCUM_EN
            acc_q  <= acc_nxt;
            data_q <= 16'(acc_nxt);
`else
            data_q <= 16'(adc_sel);
`endif
          end
        end
        SAMPLE: begin
          // Index stays put on the last sample so the accumulated word reports cap_count-1
          if (remain_q > 5'd1) idx_q <= idx_q + 6'd1;
          if (remain_q != 5'd0) remain_q <= remain_q - 5'd1;
        end
        default: ;
      endcase
    end
  end

  // A pop frees a slot in the same cycle, so push into a full FIFO succeeds then
  assign pop_ok  = wishbone_rd_en_output_buffer && !wishbone_empty_output_buffer;
  assign push_ok = push && (!wishbone_full_output_buffer || pop_ok);
  assign ovf_set = push && wishbone_full_output_buffer && !pop_ok;

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_nxt = count_q;
    if (push_ok && !pop_ok)      count_nxt = count_q + CNT_ONE;
    else if (pop_ok && !push_ok) count_nxt = count_q - CNT_ONE;
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_word;
  end

  // FIFO pointers, registered flags, head register and sticky overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr                       <= '0;
      rd_ptr                       <= '0;
      count_q                      <= '0;
      wishbone_databus_out         <= '0;
      wishbone_empty_output_buffer <= 1'b1;
      wishbone_full_output_buffer  <= 1'b0;
      overflow                     <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok) begin
        rd_ptr               <= rd_ptr + AW'(1);
        wishbone_databus_out <= mem[rd_ptr];
      end
      count_q                      <= count_nxt;
      wishbone_empty_output_buffer <= (count_nxt == '0);
      wishbone_full_output_buffer  <= (count_nxt == FULL_CNT);
      if (ovf_set)             overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_output_result_buffer.sv
// Directed bench for output_result_buffer: READ, MAC, FIFO full/overflow,
// reset mid-capture, start while busy and zero-count MAC.
module tb_output_result_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cap_start = 1'b0, cap_mode = 1'b0, cap_sel = 1'b0;
  logic [4:0]  cap_count = '0;
  logic        csa_out1 = 1'b0, csa_out2 = 1'b0;
  logic [3:0]  adc_out1 = '0, adc_out2 = '0;
  logic        en1, en2, busy;
  logic        rd_en = 1'b0, clr_ovf = 1'b0;
  logic [31:0] dout;
  logic        empty, full, ovf;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  output_result_buffer dut (
    .clk(clk), .rst(rst),
    .cap_start(cap_start), .cap_mode(cap_mode), .cap_sel(cap_sel), .cap_count(cap_count),
    .csa_out1(csa_out1), .csa_out2(csa_out2), .adc_out1(adc_out1), .adc_out2(adc_out2),
    .CLK_EN_ADC1(en1), .CLK_EN_ADC2(en2), .busy(busy),
    .wishbone_rd_en_output_buffer(rd_en), .wishbone_databus_out(dout),
    .wishbone_empty_output_buffer(empty), .wishbone_full_output_buffer(full),
    .overflow(ovf), .clear_overflow(clr_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Launch a READ capture and let it complete (start edge + 2 cycles)
  task automatic do_read(input logic sel, input logic c1, input logic c2);
    cap_mode = 1'b0; cap_sel = sel; csa_out1 = c1; csa_out2 = c2;
    cap_start = 1'b1;
    tick;
    cap_start = 1'b0;
    tick;
    tick;
  endtask

  initial begin
    logic [3:0]  vals [3];
    logic [31:0] mac_exp [3];
    vals    = '{4'd5, 4'd9, 4'd15};
    mac_exp = '{32'hC000_0005, 32'hC100_0009, 32'hC200_000F};

    // ---------------- reset state ----------------
    #2 rst = 1'b0;
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_dout", dout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_en", {en1, en2}, 0);
    tick;
    tick;
    rst = 1'b1;
    tick;
    chk("rst_rel_empty", empty, 1);

    // ---------------- READ path 1 ----------------
    cap_mode = 1'b0; cap_sel = 1'b0; csa_out1 = 1'b1; cap_start = 1'b1;
    tick;
    cap_start = 1'b0;
    chk("rd_busy_c1", busy, 1);
    chk("rd_en_c1", {en1, en2}, 0);
    tick;
    chk("rd_busy_c2", busy, 1);
    chk("rd_en_c2", {en1, en2}, 0);
    chk("rd_nopush_yet", empty, 1);
    tick;
    chk("rd_busy_done", busy, 0);
    chk("rd_pushed", empty, 0);
    rd_en = 1'b1;
    tick;
    rd_en = 1'b0;
    chk("rd_word", dout, 32'h0000_0001);
    chk("rd_empty_after", empty, 1);
    csa_out1 = 1'b0;

    // ---------------- MAC path 2, 3 samples ----------------
    cap_mode = 1'b1; cap_sel = 1'b1; cap_count = 5'd3; adc_out2 = vals[0];
    cap_start = 1'b1;
    tick;
    cap_start = 1'b0;
    for (int s = 0; s < 3; s++) begin
      adc_out2 = vals[s];
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("mac_en_s%0d_c%0d", s, c), {en1, en2}, 2'b01);
        tick;
      end
      chk($sformatf("mac_gap_s%0d", s), {en1, en2}, 0);
      chk($sformatf("mac_busy_s%0d", s), busy, 1);
      tick;
    end
    chk("mac_done", busy, 0);
`ifdef RESULT_ACCUM_EN
    rd_en = 1'b1;
    tick;
    rd_en = 1'b0;
    chk("mac_acc_word", dout, 32'hC200_001D);
`else
    rd_en = 1'b1;
    for (int w = 0; w < 3; w++) begin
      tick;
      chk($sformatf("mac_word%0d", w), dout, mac_exp[w]);
    end
    rd_en = 1'b0;
`endif
    chk("mac_drained", empty, 1);

    // ---------------- FIFO full / overflow ----------------
    for (int i = 0; i < 17; i++) begin
      do_read(i[0], !i[0], i[0]);
      if (i == 14) chk("fill15_notfull", full, 0);
      if (i == 15) begin
        chk("fill16_full", full, 1);
        chk("fill16_noovf", ovf, 0);
      end
      if (i == 16) begin
        chk("fill17_ovf", ovf, 1);
        chk("fill17_full", full, 1);
      end
    end
    clr_ovf = 1'b1;
    tick;
    clr_ovf = 1'b0;
    chk("ovf_cleared", ovf, 0);
    chk("full_kept", full, 1);
    rd_en = 1'b1;
    tick;
    chk("pop0", dout, 32'h0000_0001);
    chk("pop0_notfull", full, 0);
    tick;
    chk("pop1", dout, 32'h4000_0001);
    for (int i = 0; i < 14; i++) tick;
    rd_en = 1'b0;
    chk("pop15", dout, 32'h4000_0001);
    chk("drain_empty", empty, 1);
    rd_en = 1'b1;
    tick;
    rd_en = 1'b0;
    chk("pop_empty_hold", dout, 32'h4000_0001);
    chk("pop_empty_flag", empty, 1);

    // ---------------- reset mid-capture ----------------
    do_read(1'b0, 1'b1, 1'b0);
    chk("pre_rst_notempty", empty, 0);
    cap_mode = 1'b1; cap_sel = 1'b0; cap_count = 5'd2; cap_start = 1'b1;
    tick;
    cap_start = 1'b0;
    tick;
    chk("pre_rst_en1", {en1, en2}, 2'b10);
    rst = 1'b0;
    #1;
    chk("mid_rst_en", {en1, en2}, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_dout", dout, 0);
    #2 rst = 1'b1;
    tick;
    chk("post_rst_idle", busy, 0);
    chk("post_rst_empty", empty, 1);
    do_read(1'b1, 1'b0, 1'b1);
    rd_en = 1'b1;
    tick;
    rd_en = 1'b0;
    chk("post_rst_word", dout, 32'h4000_0001);

    // ---------------- start while busy, then count 0 ----------------
    adc_out1 = 4'd7;
    cap_mode = 1'b1; cap_sel = 1'b0; cap_count = 5'd1; cap_start = 1'b1;
    tick;
    cap_start = 1'b1; cap_mode = 1'b0; cap_sel = 1'b1;
    tick;
    cap_start = 1'b0;
    chk("busy_start_en", {en1, en2}, 2'b10);
    chk("busy_start_busy", busy, 1);
    tick;
    tick;
    tick;
    chk("busy_start_sample", busy, 1);
    tick;
    chk("busy_start_done", busy, 0);
    chk("busy_start_push", empty, 0);
    rd_en = 1'b1;
    tick;
    rd_en = 1'b0;
    chk("busy_start_word", dout, 32'h8000_0007);
    chk("busy_start_one", empty, 1);
    cap_mode = 1'b1; cap_count = 5'd0; cap_start = 1'b1;
    tick;
    cap_start = 1'b0;
    chk("cnt0_idle", busy, 0);
    chk("cnt0_en", {en1, en2}, 0);
    tick;
    tick;
    chk("cnt0_nopush", empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
